// File: rtl/popcount255_seq.sv
// Purpose: counts the 1 bits of a 255-bit word, CHUNK bits per clock, with a 3-state FSM.
// Latency: out_valid rises NCYC = 255/CHUNK edges after the input handshake (17 at CHUNK=15).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (one op in flight).
//
// Ports:
//   clk, resetn          - single clock, asynchronous active-low reset
//   in_valid/in_ready    - input handshake; din sampled only when both high
//   din[254:0]           - vector to count
//   out_valid/out_ready  - output handshake; dout stable while out_valid
//   dout[7:0]            - popcount of the accepted din (kept after out_valid clears)
//   busy                 - high in COUNT or DONE (decoded from the state register)
module popcount255_seq #(
  parameter int CHUNK = 15
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [254:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   dout,
  output logic         busy
);

  localparam int NCYC = 255 / CHUNK;

  // Only exact divisors of 255 give a whole number of counting cycles.
  generate
    if (CHUNK < 1 || (255 % CHUNK) != 0) begin : g_bad_chunk
      $error("popcount255_seq: CHUNK must divide 255");
    end
  endgenerate

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]   state;
  logic [254:0] shreg;
  logic [7:0]   acc;
  logic [7:0]   cnt;
  logic [7:0]   chunk_pc;

  // Popcount of the low CHUNK bits; at most 255, so 8 bits never overflow.
  always_comb begin
    chunk_pc = 8'd0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_pc = chunk_pc + 8'(shreg[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      shreg     <= '0;
      acc       <= 8'd0;
      cnt       <= 8'd0;
      dout      <= 8'd0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            shreg <= din;
            acc   <= 8'd0;
            cnt   <= 8'(NCYC - 1);
            state <= S_COUNT;
          end
        end
        S_COUNT: begin
          shreg <= shreg >> CHUNK;
          acc   <= acc + chunk_pc;
          if (cnt == 8'd0) begin
            // Last chunk: result goes straight to dout, bypassing acc.
            dout      <= acc + chunk_pc;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Both are pure decodes of the state register: no input reaches them combinationally.
  assign in_ready = (state == S_IDLE);
  assign busy     = (state == S_COUNT) || (state == S_DONE);

endmodule

// File: doc/popcount255_seq.md
POPCOUNT255_SEQ -- requirements
Module: popcount255_seq

Interface
REQ-001 Parameter CHUNK, default 15, sets the number of din bits counted per clock; it SHALL be restricted to divisors of 255 (1, 3, 5, 15, 17, 51, 85, 255).
REQ-002 Derived constant NCYC = 255/CHUNK SHALL be the number of counting cycles per operation (17 at default).
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream offers a din word.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 din  input  255  vector to be counted; sampled only on acceptance.
REQ-008 out_valid  output  1  dout holds a completed count.
REQ-009 out_ready  input  1  downstream accepts dout.
REQ-010 dout  output  8  number of 1 bits in the accepted din, unsigned.
REQ-011 busy  output  1  high while in the COUNT or DONE state.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, COUNT and DONE.
REQ-013 in_ready SHALL equal (state == IDLE), and no other state SHALL assert it.
REQ-014 An input handshake SHALL occur on a rising edge where in_valid and in_ready are both high.
REQ-015 On an input handshake, the block SHALL load din into a 255-bit shift register, clear the 8-bit accumulator, load the cycle counter with NCYC-1 and enter COUNT.
REQ-016 While in IDLE, in_valid low SHALL leave the state unchanged and din SHALL be ignored.
REQ-017 In COUNT, each edge SHALL:
- add popcount(shreg[CHUNK-1:0]) to the accumulator;
- shift shreg right by CHUNK, zero-filling the top bits;
- decrement the cycle counter.
REQ-018 On the COUNT edge where the counter is 0, the block SHALL write accumulator + final chunk popcount to dout, set out_valid and enter DONE.
REQ-019 out_valid SHALL therefore rise exactly NCYC edges after the input handshake edge (17 at default).
REQ-020 The accumulator SHALL be 8 bits wide; the maximum value 255 fits, so no overflow or saturation logic SHALL exist.
REQ-021 In DONE, out_valid and dout SHALL be held stable until out_ready is sampled high.
REQ-022 On the DONE edge with out_ready high, out_valid SHALL clear and the state SHALL return to IDLE.
REQ-023 in_ready SHALL rise in the cycle after the output handshake; accepting new input in the same cycle as the output handshake is not supported.
REQ-024 Minimum spacing between input handshakes SHALL be NCYC+2 cycles.
REQ-025 After out_valid clears, dout SHALL retain the last result until the next completion.
REQ-026 Changes to din or in_valid during COUNT or DONE SHALL have no effect.
REQ-027 With CHUNK=255, COUNT SHALL last one cycle and out_valid SHALL rise 1 edge after the input handshake.
REQ-028 busy SHALL be registered state decode, with no combinational path from any input.

Reset
REQ-029 resetn low SHALL immediately force the following, regardless of the clock:
- state IDLE;
- out_valid 0;
- dout 8'h00;
- accumulator, counter and shreg all zero;
- busy 0.
REQ-030 While resetn is low, in_ready SHALL read 1 (state IDLE) but no handshake SHALL be taken.
REQ-031 Reset asserted mid-COUNT or mid-DONE SHALL abandon the operation with no output produced.
REQ-032 The first rising edge after resetn deasserts SHALL be able to accept input.

Verification
REQ-033 The bench SHALL cover at least these directed scenarios:
- din=0, out_ready=1 -> out_valid high 17 edges after accept, dout=0.
- din=all ones -> dout=8'hFF (255).
- din=255'haaaa -> dout=8; then din=255'hf00000 -> dout=4; din=255'h7 -> dout=3.
- Accept 255'h3, hold out_ready=0 for 5 cycles while toggling in_valid and din -> out_valid stays 1, dout=2, in_ready stays 0, no second capture.
- Reset pulsed 8 cycles into COUNT -> out_valid=0, dout=0, busy=0, in_ready=1; the next operation on din=255'h1 gives dout=1.
- 200 random 255-bit vectors with random out_ready stalls -> every dout matches a popcount reference; repeat with CHUNK=1 (latency 255) and CHUNK=255 (latency 1).
